// File: rtl/player_ctl_if.sv
// Signal bundle between the frame timing / button logic and the player movement controller.
// The controller side uses the slave modport; the source side (timing chain, buttons, sprite) uses master.
interface player_ctl_if;
    logic       vblnk;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] player_xpos;
    logic [9:0] player_ypos;
    logic       dirction;
    logic       airborne;

    modport master (
        output vblnk, btn_left, btn_right, btn_jump,
        input  player_xpos, player_ypos, dirction, airborne
    );

    modport slave (
        input  vblnk, btn_left, btn_right, btn_jump,
        output player_xpos, player_ypos, dirction, airborne
    );
endinterface

// File: rtl/player_ctl.sv
// Per-frame player movement: saturating horizontal steps plus a jump/gravity FSM,
// all state advancing once per frame on the rising edge of vblnk.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_GROUND | standing on the floor row, waiting for a pending jump
// S_RISE   | moving up, speed decays by GRAVITY each frame
// S_FALL   | moving down, speed grows to VY_MAX until the floor is hit
module player_ctl #(
    parameter int X_INIT  = 10,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 958,
    parameter int Y_FLOOR = 292,
    parameter int Y_MIN   = 0,
    parameter int STEP    = 4,
    parameter int JUMP_V0 = 12,
    parameter int GRAVITY = 1,
    parameter int VY_MAX  = 12
) (
    input logic         clk,
    input logic         rst,
    player_ctl_if.slave bus
);
    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_RISE   = 2'd1,
        S_FALL   = 2'd2
    } state_t;

    localparam logic signed [10:0] C_X_MIN   = 11'(X_MIN);
    localparam logic signed [10:0] C_X_MAX   = 11'(X_MAX);
    localparam logic signed [10:0] C_Y_MIN   = 11'(Y_MIN);
    localparam logic signed [10:0] C_Y_FLOOR = 11'(Y_FLOOR);
    localparam logic signed [10:0] C_STEP    = 11'(STEP);

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_btn_s1, r_btn_s2;  // {jump, right, left}
    logic               r_jump_q, r_vblnk_q;
    logic               r_jump_pend, w_jump_pend_nxt;
    logic [9:0]         r_x, w_x_nxt, r_y, w_y_nxt;
    logic [4:0]         r_vy, w_vy_nxt;
    logic               r_dir, w_dir_nxt, r_airborne;
    logic               w_tick, w_jump_rise, w_left, w_right;
    logic signed [10:0] w_x_ext, w_x_sub, w_x_add;
    logic signed [10:0] w_y_ext, w_y_sub, w_y_add;
    logic [5:0]         w_vy_inc, w_vn;

    assign w_tick      = bus.vblnk & ~r_vblnk_q;
    assign w_jump_rise = r_btn_s2[2] & ~r_jump_q;
    assign w_left      = r_btn_s2[0];
    assign w_right     = r_btn_s2[1];

    // All position math is done 11 bits wide so nothing wraps before saturation.
    assign w_x_ext  = $signed({1'b0, r_x});
    assign w_x_sub  = w_x_ext - C_STEP;
    assign w_x_add  = w_x_ext + C_STEP;
    assign w_y_ext  = $signed({1'b0, r_y});
    assign w_y_sub  = w_y_ext - $signed({6'b0, r_vy});
    assign w_vy_inc = {1'b0, r_vy} + 6'(GRAVITY);
    assign w_vn     = (w_vy_inc > 6'(VY_MAX)) ? 6'(VY_MAX) : w_vy_inc;
    assign w_y_add  = w_y_ext + $signed({5'b0, w_vn});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_GROUND;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_dir_nxt       = r_dir;
        w_y_nxt         = r_y;
        w_vy_nxt        = r_vy;
        w_jump_pend_nxt = r_jump_pend;

        if (w_tick) begin
            if (w_left && !w_right) begin
                w_x_nxt   = (w_x_sub < C_X_MIN) ? C_X_MIN[9:0] : w_x_sub[9:0];
                w_dir_nxt = 1'b0;
            end else if (w_right && !w_left) begin
                w_x_nxt   = (w_x_add > C_X_MAX) ? C_X_MAX[9:0] : w_x_add[9:0];
                w_dir_nxt = 1'b1;
            end
        end

        case (r_state)
            S_GROUND: begin
                if (w_tick && r_jump_pend) begin
                    w_state_nxt     = S_RISE;
                    w_vy_nxt        = 5'(JUMP_V0);
                    w_jump_pend_nxt = 1'b0;
                end
            end
            S_RISE: begin
                if (w_tick) begin
                    if (w_y_sub <= C_Y_MIN) begin
                        w_y_nxt     = C_Y_MIN[9:0];
                        w_vy_nxt    = 5'd0;
                        w_state_nxt = S_FALL;
                    end else begin
                        w_y_nxt  = w_y_sub[9:0];
                        w_vy_nxt = r_vy - 5'(GRAVITY);
                        if (r_vy <= 5'(GRAVITY)) begin
                            w_state_nxt = S_FALL;
                        end
                    end
                end
            end
            S_FALL: begin
                if (w_tick) begin
                    if (w_y_add >= C_Y_FLOOR) begin
                        w_y_nxt     = C_Y_FLOOR[9:0];
                        w_vy_nxt    = 5'd0;
                        w_state_nxt = S_GROUND;
                    end else begin
                        w_y_nxt  = w_y_add[9:0];
                        w_vy_nxt = w_vn[4:0];
                    end
                end
            end
            default: w_state_nxt = S_FALL;
        endcase

        // A fresh press wins over consumption; it can only fire on a later tick.
        if (w_jump_rise) begin
            w_jump_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_s1    <= 3'b000;
            r_btn_s2    <= 3'b000;
            r_jump_q    <= 1'b0;
            r_vblnk_q   <= 1'b0;
            r_jump_pend <= 1'b0;
            r_x         <= 10'(X_INIT);
            r_y         <= C_Y_FLOOR[9:0];
            r_vy        <= 5'd0;
            r_dir       <= 1'b1;
            r_airborne  <= 1'b0;
        end else begin
            r_btn_s1    <= {bus.btn_jump, bus.btn_right, bus.btn_left};
            r_btn_s2    <= r_btn_s1;
            r_jump_q    <= r_btn_s2[2];
            r_vblnk_q   <= bus.vblnk;
            r_jump_pend <= w_jump_pend_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vy        <= w_vy_nxt;
            r_dir       <= w_dir_nxt;
            r_airborne  <= (w_state_nxt != S_GROUND);
        end
    end

    assign bus.player_xpos = r_x;
    assign bus.player_ypos = r_y;
    assign bus.dirction    = r_dir;
    assign bus.airborne    = r_airborne;
endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl: default instance plus a second instance with a raised ceiling.
`timescale 1ns/1ps
module tb_player_ctl;
    logic clk;
    logic rst;
    logic vblnk, btn_left, btn_right, btn_jump;
    int   n_tests;
    int   n_fail;

    player_ctl_if bus ();
    player_ctl_if bus2 ();

    assign bus.vblnk      = vblnk;
    assign bus.btn_left   = btn_left;
    assign bus.btn_right  = btn_right;
    assign bus.btn_jump   = btn_jump;
    assign bus2.vblnk     = vblnk;
    assign bus2.btn_left  = btn_left;
    assign bus2.btn_right = btn_right;
    assign bus2.btn_jump  = btn_jump;

    player_ctl u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    player_ctl #(.Y_MIN(250)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        vblnk = 1'b1;
        @(posedge clk);
        #1;
        wait_clk(2);
        vblnk = 1'b0;
        wait_clk(2);
    endtask

    task automatic press_jump();
        btn_jump = 1'b1;
        wait_clk(4);
        btn_jump = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.player_xpos !== 10'd10) begin n_fail++; $display("FAIL reset_x: got %0d want 10", bus.player_xpos); end
        n_tests++; if (bus.player_ypos !== 10'd292) begin n_fail++; $display("FAIL reset_y: got %0d want 292", bus.player_ypos); end
        n_tests++; if (bus.dirction !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", bus.dirction); end
        n_tests++; if (bus.airborne !== 1'b0) begin n_fail++; $display("FAIL reset_air: got %b want 0", bus.airborne); end
        frame();
        frame();
        n_tests++; if (bus.player_xpos !== 10'd10 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL idle_frames: got x=%0d y=%0d want x=10 y=292", bus.player_xpos, bus.player_ypos);
        end
    endtask

    task automatic test_left();
        logic [9:0] exp_x [5];
        exp_x = '{10'd6, 10'd2, 10'd0, 10'd0, 10'd0};
        do_reset();
        btn_left = 1'b1;
        wait_clk(3);
        for (int i = 0; i < 5; i++) begin
            frame();
            n_tests++; if (bus.player_xpos !== exp_x[i]) begin
                n_fail++; $display("FAIL left_x[%0d]: got %0d want %0d", i, bus.player_xpos, exp_x[i]);
            end
            if (i == 0) begin
                n_tests++; if (bus.dirction !== 1'b0) begin n_fail++; $display("FAIL left_dir: got %b want 0", bus.dirction); end
            end
        end
        btn_right = 1'b1;
        wait_clk(3);
        frame();
        n_tests++; if (bus.player_xpos !== 10'd0 || bus.dirction !== 1'b0) begin
            n_fail++; $display("FAIL both_hold: got x=%0d dir=%b want x=0 dir=0", bus.player_xpos, bus.dirction);
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_right();
        do_reset();
        btn_right = 1'b1;
        wait_clk(3);
        repeat (235) frame();
        n_tests++; if (bus.player_xpos !== 10'd950) begin n_fail++; $display("FAIL right_start: got %0d want 950", bus.player_xpos); end
        wait_clk(5);
        n_tests++; if (bus.player_xpos !== 10'd950) begin n_fail++; $display("FAIL right_midframe: got %0d want 950", bus.player_xpos); end
        @(negedge clk);
        vblnk = 1'b1;
        #1;
        n_tests++; if (bus.player_xpos !== 10'd950) begin n_fail++; $display("FAIL right_pre_edge: got %0d want 950", bus.player_xpos); end
        @(posedge clk);
        #1;
        n_tests++; if (bus.player_xpos !== 10'd954) begin n_fail++; $display("FAIL right_x0: got %0d want 954", bus.player_xpos); end
        wait_clk(2);
        vblnk = 1'b0;
        wait_clk(4);
        n_tests++; if (bus.player_xpos !== 10'd954) begin n_fail++; $display("FAIL right_stable: got %0d want 954", bus.player_xpos); end
        frame();
        n_tests++; if (bus.player_xpos !== 10'd958) begin n_fail++; $display("FAIL right_x1: got %0d want 958", bus.player_xpos); end
        frame();
        n_tests++; if (bus.player_xpos !== 10'd958 || bus.dirction !== 1'b1) begin
            n_fail++; $display("FAIL right_sat: got x=%0d dir=%b want x=958 dir=1", bus.player_xpos, bus.dirction);
        end
        btn_right = 1'b0;
        wait_clk(3);
    endtask

    // Hand-derived y trajectory after the entry tick: rise by 12..1, fall by 1..12.
    task automatic test_single_jump();
        int exp_y [24];
        exp_y = '{280, 269, 259, 250, 242, 235, 229, 224, 220, 217, 215, 214,
                  215, 217, 220, 224, 229, 235, 242, 250, 259, 269, 280, 292};
        do_reset();
        press_jump();
        frame();
        n_tests++; if (bus.airborne !== 1'b1 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL jump_entry: got air=%b y=%0d want air=1 y=292", bus.airborne, bus.player_ypos);
        end
        for (int i = 0; i < 24; i++) begin
            frame();
            n_tests++; if (bus.player_ypos !== 10'(exp_y[i])) begin
                n_fail++; $display("FAIL jump_y[%0d]: got %0d want %0d", i, bus.player_ypos, exp_y[i]);
            end
            n_tests++; if (bus.airborne !== (i != 23)) begin
                n_fail++; $display("FAIL jump_air[%0d]: got %b want %b", i, bus.airborne, (i != 23));
            end
        end
        frame();
        n_tests++; if (bus.airborne !== 1'b0 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL jump_after: got air=%b y=%0d want air=0 y=292", bus.airborne, bus.player_ypos);
        end
    endtask

    task automatic test_held_jump();
        do_reset();
        btn_jump = 1'b1;
        wait_clk(4);
        repeat (25) frame();
        n_tests++; if (bus.airborne !== 1'b0 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL held_land: got air=%b y=%0d want air=0 y=292", bus.airborne, bus.player_ypos);
        end
        repeat (3) frame();
        n_tests++; if (bus.airborne !== 1'b0 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL held_no_rejump: got air=%b y=%0d want air=0 y=292", bus.airborne, bus.player_ypos);
        end
        btn_jump = 1'b0;
        wait_clk(4);
        press_jump();
        frame();
        n_tests++; if (bus.airborne !== 1'b1) begin n_fail++; $display("FAIL repress_entry: got air=%b want 1", bus.airborne); end
        repeat (14) frame();
        n_tests++; if (bus.player_ypos !== 10'd217) begin n_fail++; $display("FAIL repress_fall_y: got %0d want 217", bus.player_ypos); end
        press_jump();
        repeat (10) frame();
        n_tests++; if (bus.airborne !== 1'b0 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL pend_land: got air=%b y=%0d want air=0 y=292", bus.airborne, bus.player_ypos);
        end
        frame();
        n_tests++; if (bus.airborne !== 1'b1 || bus.player_ypos !== 10'd292) begin
            n_fail++; $display("FAIL pend_fire: got air=%b y=%0d want air=1 y=292", bus.airborne, bus.player_ypos);
        end
        frame();
        n_tests++; if (bus.player_ypos !== 10'd280) begin n_fail++; $display("FAIL pend_rise: got %0d want 280", bus.player_ypos); end
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        press_jump();
        frame();
        repeat (3) frame();
        press_jump();
        repeat (9) frame();
        n_tests++; if (bus.player_ypos !== 10'd214) begin n_fail++; $display("FAIL apex_y: got %0d want 214", bus.player_ypos); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (bus.player_ypos !== 10'd292 || bus.airborne !== 1'b0 || bus.player_xpos !== 10'd10) begin
            n_fail++; $display("FAIL midrst: got y=%0d air=%b x=%0d want y=292 air=0 x=10", bus.player_ypos, bus.airborne, bus.player_xpos);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) frame();
        n_tests++; if (bus.player_ypos !== 10'd292 || bus.airborne !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_jump: got y=%0d air=%b want y=292 air=0", bus.player_ypos, bus.airborne);
        end
    endtask

    task automatic test_ceiling();
        int exp_y [13];
        exp_y = '{280, 269, 259, 250, 251, 253, 256, 260, 265, 271, 278, 286, 292};
        do_reset();
        press_jump();
        frame();
        for (int i = 0; i < 13; i++) begin
            frame();
            n_tests++; if (bus2.player_ypos !== 10'(exp_y[i])) begin
                n_fail++; $display("FAIL ceil_y[%0d]: got %0d want %0d", i, bus2.player_ypos, exp_y[i]);
            end
            n_tests++; if (bus2.airborne !== (i != 12)) begin
                n_fail++; $display("FAIL ceil_air[%0d]: got %b want %b", i, bus2.airborne, (i != 12));
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        vblnk = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_jump = 1'b0;
        test_reset();
        test_left();
        test_right();
        test_single_jump();
        test_held_jump();
        test_reset_mid_jump();
        test_ceiling();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/player_ctl.md
# player_ctl

Per-frame player movement controller that sits directly upstream of `draw_player`. It produces `player_xpos`, `player_ypos` and `dirction` from the debounced board buttons. State updates exactly once per frame, on the rising edge of `vblnk`, so the sprite position stays constant during active video. Horizontal motion saturates at the screen edges; vertical motion is a jump/gravity state machine that always lands on the floor row.

## Interface
Parameters:
- `X_INIT`, 10: x position after reset.
- `X_MIN`, 0: left saturation limit.
- `X_MAX`, 958: right saturation limit (1024 − 64 − 2, the sprite draw offset).
- `Y_FLOOR`, 292: ground row (100 + 64·3); also the reset y.
- `Y_MIN`, 0: ceiling.
- `STEP`, 4: horizontal pixels per frame.
- `JUMP_V0`, 12: initial upward speed in px/frame.
- `GRAVITY`, 1: speed change per frame.
- `VY_MAX`, 12: fall speed cap.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `vblnk`  in  1  vertical blank from the timing chain.
- `btn_left`  in  1  asynchronous, level.
- `btn_right`  in  1  asynchronous, level.
- `btn_jump`  in  1  asynchronous, level.
- `player_xpos`  out  10  sprite left edge, registered.
- `player_ypos`  out  10  sprite top edge, registered.
- `dirction`  out  1  1 = facing right, 0 = facing left.
- `airborne`  out  1  high in RISE or FALL.

## Operation
- **Input synchronisation.** All three buttons pass through a 2-flop synchroniser before any logic uses them.
- **Frame tick.** `tick` = `vblnk` & ~`vblnk_q`, a one-cycle pulse. All state below changes only in the cycle where `tick` = 1.
- **Jump request latch.**
  - `jump_pend` is set on a rising edge of synced `btn_jump`.
  - It is cleared when the GROUND state consumes it.
  - A held button produces exactly one jump; the button must be released and pressed again for the next one.
  - A press while airborne stays pending and fires on the first tick after landing.
- **Horizontal motion (every tick, independent of vertical state).**
  - Left only: x ← (x < X_MIN+STEP) ? X_MIN : x−STEP; `dirction` ← 0.
  - Right only: x ← (x > X_MAX−STEP) ? X_MAX : x+STEP; `dirction` ← 1.
  - Both or neither: x and `dirction` hold.
  - x never wraps.
- **Vertical FSM.** States are GROUND, RISE and FALL. `vy` is a 5-bit unsigned magnitude; its direction is implied by the state.
  - GROUND, on tick with `jump_pend`: state ← RISE, `vy` ← JUMP_V0, `jump_pend` ← 0. y does not change on this tick.
  - RISE, on tick:
    - y ← y − `vy`.
    - If y − `vy` ≤ Y_MIN: y ← Y_MIN, `vy` ← 0, state ← FALL.
    - Otherwise `vy` ← `vy` − GRAVITY; if `vy` ≤ GRAVITY, state ← FALL.
  - FALL, on tick:
    - `vn` = min(`vy` + GRAVITY, VY_MAX).
    - If y + `vn` ≥ Y_FLOOR: y ← Y_FLOOR, `vy` ← 0, state ← GROUND.
    - Otherwise y ← y + `vn`, `vy` ← `vn`.
- **Arithmetic.** All y and x sums and differences are computed 11 bits wide, signed or with extended compare, before saturation. Outputs are always within [X_MIN, X_MAX] and [Y_MIN, Y_FLOOR].
- **Invalid state.** An unused state encoding recovers to FALL.
- **Reset values.**
  - `player_xpos` = X_INIT (10), `player_ypos` = Y_FLOOR (292).
  - `dirction` = 1, `airborne` = 0.
  - State GROUND, `vy` = 0, `jump_pend` = 0, synchroniser and `vblnk_q` = 0.

## Timing
- Button to synced value: 2 clk.
- `vblnk` rise to `tick`: combinational on `vblnk_q`. Outputs update at the clk edge ending the `tick` cycle, i.e. 1 clk after the `vblnk` rise is sampled.
- Outputs are stable for the whole frame between ticks.
- `airborne` is registered with the state and changes in the same cycle as the state.
- Simultaneous `tick` and jump rising edge: the edge sets `jump_pend`. It is consumed on the next tick, never the same one.
- `rst` mid-jump: all registers return to reset values on the next edge. No pending jump survives reset.
- Full jump with default parameters:
  - Entry tick.
  - 12 RISE ticks (y −12 … −1, total 78, apex y = 214).
  - 12 FALL ticks (+1 … +12, lands exactly at 292).
  - Total 25 ticks from the press-consuming tick to GROUND.

## Test plan
- **Reset.** Assert `rst` 3 clk → x = 10, y = 292, `dirction` = 1, `airborne` = 0. Toggle `vblnk` with no buttons → outputs unchanged.
- **Left saturation.** Hold `btn_left` for 5 frames from reset → x: 6, 2, 0, 0, 0. `dirction` = 0 after the first tick. Left + right together → x and `dirction` hold.
- **Right saturation.** Hold `btn_right` from x = 950 → x = 954, 958, 958. Outputs change only 1 clk after each `vblnk` rise, never mid-frame.
- **Single jump.** Press `btn_jump` once → `airborne` rises on the next tick. y sequence 292, 280, 269, …, 214 (apex after 12 RISE ticks), then back down to exactly 292. GROUND reached after 25 ticks; y never exceeds 292.
- **Held jump.** Keep `btn_jump` held through landing → no second jump. Release, then press during FALL → a new jump starts on the first tick after landing.
- **Reset mid-jump.** Assert `rst` at apex → y = 292, `airborne` = 0, no re-jump on later ticks. Set Y_MIN = 250 → y clamps to 250, then FALL begins with `vy` = 0.
